// File: rtl/float_pkg.sv
// Shared binary32 definitions for the GPU float datapath: field widths,
// exponent bias, the packed float layout and the multiplier FSM states.
package float_pkg;

  localparam int float_width      = 32;
  localparam int float_exp_width  = 8;
  localparam int float_mant_width = 23;
  localparam int float_exp_bias   = 127;

  // Significand including the hidden bit, and the full double-width product.
  localparam int sig_width  = float_mant_width + 1;
  localparam int prod_width = 2 * sig_width;
  localparam int mul_steps  = sig_width;

  typedef struct packed {
    logic                        sign;
    logic [float_exp_width-1:0]  exp;
    logic [float_mant_width-1:0] mant;
  } float_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM
  } state_e;

  // Signed zero or signed infinity with the given sign.
  function automatic float_t float_special(input logic sign, input logic is_inf);
    float_t f;
    f.sign = sign;
    f.exp  = is_inf ? '1 : '0;
    f.mant = '0;
    return f;
  endfunction

endpackage

// File: rtl/float_mul_pipeline_mant.sv
// 24x24 sequential shift-add significand multiplier. A start pulse loads the
// operands and clears the accumulator; one partial product is added per clock.
// done is high during the final add cycle, so product is complete on the
// cycle after done.
module float_mant_mul_seq
  import float_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [sig_width-1:0]  mcand,
  input  logic [sig_width-1:0]  mplier,
  output logic                  done,
  output logic [prod_width-1:0] product
);

  logic                  busy_q, busy_d;
  logic [4:0]            step_q, step_d;
  logic [prod_width-1:0] mcand_q, mcand_d;
  logic [sig_width-1:0]  mplier_q, mplier_d;
  logic [prod_width-1:0] acc_q, acc_d;

  assign done    = busy_q && (step_q == 5'(mul_steps - 1));
  assign product = acc_q;

  // Next-state: load on start, otherwise one shift-add step while busy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    busy_d   = busy_q;
    step_d   = step_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      step_d   = '0;
      mcand_d  = {{sig_width{1'b0}}, mcand};
      mplier_d = mplier;
      acc_d    = '0;
    end else if (busy_q) begin
      // Multiplicand shifts left and multiplier shifts right, so bit 0 of
      // the multiplier always selects multiplicand<<step.
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      step_d   = step_q + 5'd1;
      if (done) busy_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (rst) begin
      busy_q   <= 1'b0;
      step_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      step_q   <= step_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/float_mul_pipeline.sv
// Multi-cycle binary32 multiplier with a req/ack handshake.
// Zero/denormal operands complete in one cycle; all others take 25 cycles
// (capture, 24 shift-add steps, normalise).
// Optional macro FLOAT_MUL_RNE_EN: round to nearest even in the NORM cycle
// instead of truncating.
module float_mul_pipeline
  import float_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  output logic                   ack,
  input  logic [float_width-1:0] a,
  input  logic [float_width-1:0] b,
  output logic [float_width-1:0] out
);

  float_t fa, fb;
  assign fa = a;
  assign fb = b;

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [7:0]            ea_q, ea_d;
  logic [7:0]            eb_q, eb_d;
  logic                  zero_q, zero_d;
  float_t                out_q, out_d;
  logic                  ack_q, ack_d;

  logic                  mul_start;
  logic                  mul_done;
  logic [prod_width-1:0] product;
  float_t                norm_res;

  float_mant_mul_seq u_mant_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .mcand   ({1'b1, fa.mant}),
    .mplier  ({1'b1, fb.mant}),
    .done    (mul_done),
    .product (product)
  );

  // Normalise, round and range-check the finished product.
  always_comb begin
    logic signed [9:0] exp_base;
    logic signed [9:0] exp_res;
    logic [22:0]       mant;
`ifdef FLOAT_MUL_RNE_EN
    logic              guard;
    logic              sticky;
    logic [23:0]       mant_rnd;
`endif
    exp_base = 10'(ea_q) + 10'(eb_q) - 10'(float_exp_bias);
    if (product[prod_width-1]) begin
      mant    = product[46:24];
      exp_res = exp_base + 10'sd1;
    end else begin
      mant    = product[45:23];
      exp_res = exp_base;
    end
`ifdef FLOAT_MUL_RNE_EN
    guard  = product[prod_width-1] ? product[23] : product[22];
    sticky = product[prod_width-1] ? (|product[22:0]) : (|product[21:0]);
    mant_rnd = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
    // A carry out of the mantissa means 1.111..1 rounded up to 10.0.
    if (mant_rnd[23]) exp_res = exp_res + 10'sd1;
    mant = mant_rnd[22:0];
`endif
    if (zero_q || exp_res <= 10'sd0) begin
      norm_res = float_special(sign_q, 1'b0);
    end else if (exp_res >= 10'sd255) begin
      norm_res = float_special(sign_q, 1'b1);
    end else begin
      norm_res.sign = sign_q;
      norm_res.exp  = exp_res[7:0];
      norm_res.mant = mant;
    end
  end

`ifndef FLOAT_MUL_RNE_EN
  // Bits below the guard position only matter when rounding.
  logic prod_low_unused;
  assign prod_low_unused = |product[22:0];
`endif

  // Handshake FSM: capture in IDLE, iterate in MUL, publish in NORM.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    zero_d    = zero_q;
    out_d     = out_q;
    ack_d     = 1'b0;
    mul_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The ack cycle still belongs to the previous operation.
        if (req && !ack_q) begin
          sign_d = fa.sign ^ fb.sign;
          ea_d   = fa.exp;
          eb_d   = fb.exp;
          if (fa.exp == '0 || fb.exp == '0) begin
            // Denormals flush to zero; NORM publishes the signed zero.
            zero_d  = 1'b1;
            state_d = NORM;
          end else begin
            zero_d    = 1'b0;
            mul_start = 1'b1;
            state_d   = MUL;
          end
        end
      end
      MUL: begin
        if (mul_done) state_d = NORM;
      end
      NORM: begin
        out_d   = norm_res;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      zero_q  <= 1'b0;
      out_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      zero_q  <= zero_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
    end
  end

  assign ack = ack_q;
  assign out = out_q;

endmodule

// File: tb/tb_float_mul_pipeline.sv
// Scoreboard bench for float_mul_pipeline: stimulus pushes expected result and
// completion cycle; a monitor compares each ack against the queue head.
module tb_float_mul_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] a   = '0;
  logic [31:0] b   = '0;
  logic        ack;
  logic [31:0] out;

  float_mul_pipeline dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .ack (ack),
    .a   (a),
    .b   (b),
    .out (out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int unsigned at;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, want);
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ack) begin
      check("ack_one_cycle", 32'(prev_ack), 32'd0);
      check("ack_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check({e.name, "_out"}, out, e.val);
        check({e.name, "_cycle"}, cyc, e.at);
      end
    end
    prev_ack <= ack;
  end

  // Called just after a rising edge; returns just after the sampling edge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ev, input int lat, input string nm);
    exp_t e;
    a   = av;
    b   = bv;
    req = 1'b1;
    @(posedge clk);
    #1;
    req    = 1'b0;
    e.val  = ev;
    e.at   = cyc + int'(lat);
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for ack, then returns just after the following edge.
  task automatic wait_ack(input string nm);
    logic got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    check({nm, "_ack_seen"}, 32'(got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] ev, input int lat, input string nm);
    issue(av, bv, ev, lat, nm);
    wait_ack(nm);
  endtask

  localparam logic [31:0] F_0     = 32'h0000_0000;
  localparam logic [31:0] F_1     = 32'h3F80_0000;
  localparam logic [31:0] F_2     = 32'h4000_0000;
  localparam logic [31:0] F_M2    = 32'hC000_0000;
  localparam logic [31:0] F_3     = 32'h4040_0000;
  localparam logic [31:0] F_4     = 32'h4080_0000;
  localparam logic [31:0] F_8     = 32'h4100_0000;
  localparam logic [31:0] F_11    = 32'h4130_0000;
  localparam logic [31:0] F_100   = 32'h42C8_0000;
  localparam logic [31:0] F_200   = 32'h4348_0000;
  localparam logic [31:0] F_2000  = 32'h44FA_0000;
  localparam logic [31:0] F_M2000 = 32'hC4FA_0000;
  localparam logic [31:0] F_1P1   = 32'h3F8C_CCCD;
  localparam logic [31:0] F_1P9   = 32'h3FF3_3333;
  localparam logic [31:0] F_2P3   = 32'h4013_3333;
  localparam logic [31:0] F_M2P3  = 32'hC013_3333;
  localparam logic [31:0] F_1E38  = 32'h7E96_7699;
  localparam logic [31:0] F_M1E38 = 32'hFE96_7699;
  localparam logic [31:0] F_1EM20 = 32'h1E3C_E508;
  localparam logic [31:0] F_1EM38 = 32'h006C_E3EE;

`ifdef FLOAT_MUL_RNE_EN
  localparam logic [31:0] R_3X1P1 = 32'h4053_3334;
`else
  localparam logic [31:0] R_3X1P1 = 32'h4053_3333;
`endif

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_out", out, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero fast path, one-cycle latency.
    run(F_0, F_1, 32'h0000_0000, 1, "zero_a");
    run(F_1, F_0, 32'h0000_0000, 1, "zero_b");
    run(F_0, F_0, 32'h0000_0000, 1, "zero_both");
    run(F_M2, F_0, 32'h8000_0000, 1, "zero_neg");

    // Main path, both normalisation branches, 25-cycle latency.
    run(F_1,   F_1,   32'h3F80_0000, 25, "one_one");
    run(F_1P9, F_1P9, 32'h4067_0A3D, 25, "m1p9_sq");
    run(F_11,  F_11,  32'h42F2_0000, 25, "m11_sq");
    run(F_2,   F_2P3, 32'h4093_3333, 25, "m2_2p3");
    run(F_8,   F_4,   32'h4200_0000, 25, "m8_4");
    run(F_200, F_100, 32'h469C_4000, 25, "m200_100");
    run(F_2000, F_2P3, 32'h458F_BFFF, 25, "m2000_2p3");

    // Signs.
    run(F_M2000, F_2P3,  32'hC58F_BFFF, 25, "neg_a");
    run(F_2000,  F_M2P3, 32'hC58F_BFFF, 25, "neg_b");
    run(F_M2000, F_M2P3, 32'h458F_BFFF, 25, "neg_ab");

    // Range limits.
    run(F_1E38,  F_1E38,  32'h7F80_0000, 25, "overflow_pos");
    run(F_M1E38, F_1E38,  32'hFF80_0000, 25, "overflow_neg");
    run(F_1EM20, F_1EM20, 32'h0000_0000, 25, "underflow");
    run(F_1EM38, F_1EM38, 32'h0000_0000, 1,  "denormal_flush");

    // Rounding: 1.1*1.1 is unaffected; 3*1.1 is an exact tie.
    run(F_1P1, F_1P1, 32'h3F9A_E148, 25, "m1p1_sq");
    run(F_3,   F_1P1, R_3X1P1,       25, "m3_1p1_tie");

    // req held through MUL yields exactly one result.
    a   = F_2;
    b   = F_4;
    req = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back('{32'h4100_0000, cyc + 25, "req_held"});
    repeat (9) @(posedge clk);
    #1;
    req = 1'b0;
    wait_ack("req_held");

    // req during the ack cycle is ignored.
    issue(F_0, F_4, 32'h0000_0000, 1, "zero_then_req");
    @(posedge clk);
    #1;
    a   = F_2;
    b   = F_2;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    // Abort mid-MUL: no ack, out cleared. Prime out with a non-zero result.
    run(F_8, F_4, 32'h4200_0000, 25, "before_abort");
    issue(F_2, F_2, 32'h0, 0, "abort_placeholder");
    void'(sb_q.pop_back());
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("abort_out", out, 32'h0);
    check("abort_ack", 32'(ack), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_out_held", out, 32'h0);

    // Recovery after abort.
    run(F_11, F_11, 32'h42F2_0000, 25, "after_abort");

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
